// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master transaction sequencer.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    TX_BYTE,
    TX_ACK,
    RSTART,
    RX_BYTE,
    RX_NACK,
    STOP,
    DONE
  } state_t;

  // Quarter-bit phase that the next tick executes
  localparam logic [1:0] PH_LOW  = 2'd0;
  localparam logic [1:0] PH_RISE = 2'd1;
  localparam logic [1:0] PH_HIGH = 2'd2;
  localparam logic [1:0] PH_FALL = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: down-counter reloaded to CLK_DIV-1, one-cycle
// tick at terminal count. Parked at the reload value while disabled so the
// first tick lands CLK_DIV cycles after enable; hold freezes the count.
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !hold && (cnt == '0);

  // Down-counter with terminal-count reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= RELOAD;
    end else if (!hold) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_seq.sv
// Single-master I2C byte write / byte read sequencer with open-drain enables.
// Optional slave clock stretching is compiled in with I2C_STRETCH_EN.
//
// state   | meaning
// IDLE    | waiting for a command, bus released
// START   | S condition: SDA falls while SCL high, then SCL low
// TX_BYTE | shifting out DEV+W, MADR, DATA or DEV+R, MSB first
// TX_ACK  | SDA released, slave ACK sampled on SCL high
// RSTART  | repeated start before DEV+R
// RX_BYTE | SDA released, read byte shifted in MSB first
// RX_NACK | master leaves SDA high for the 9th bit
// STOP    | P condition: SDA rises while SCL high
// DONE    | one-cycle response strobe
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_adr,
  input  logic [7:0] cmd_mem_adr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  state_t     state, state_d;
  logic [1:0] phase, phase_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [1:0] byte_idx, byte_idx_d;
  logic [7:0] tx_sh, tx_sh_d, rx_sh, rx_sh_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] madr_q, madr_d, wdata_q, wdata_d;
  logic       ack_q, ack_d, nack_q, nack_d;
  logic       scl_oe_d, sda_oe_d;
  logic [7:0] rsp_rdata_d;
  logic       rsp_nack_d;
  logic       tick, stretch_hold;

`ifdef I2C_STRETCH_EN
  // Slave holding SCL low freezes the high phase until the line is seen high
  assign stretch_hold = (phase == PH_HIGH) && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stretch_hold = 1'b0;
`endif

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state != IDLE),
    .hold (stretch_hold),
    .tick (tick)
  );

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE) && (state != DONE);

  // State and datapath registers; reset releases both bus lines at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= PH_LOW;
      bit_cnt   <= 3'd0;
      byte_idx  <= 2'd0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      rw_q      <= RW_WRITE;
      dev_q     <= 7'h00;
      madr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      bit_cnt   <= bit_cnt_d;
      byte_idx  <= byte_idx_d;
      tx_sh     <= tx_sh_d;
      rx_sh     <= rx_sh_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      madr_q    <= madr_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      scl_oe    <= scl_oe_d;
      sda_oe    <= sda_oe_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_nack  <= rsp_nack_d;
    end
  end

  // Next-state and line control; each tick executes the current phase
  always_comb begin
    state_d     = state;
    phase_d     = phase;
    bit_cnt_d   = bit_cnt;
    byte_idx_d  = byte_idx;
    tx_sh_d     = tx_sh;
    rx_sh_d     = rx_sh;
    rw_d        = rw_q;
    dev_d       = dev_q;
    madr_d      = madr_q;
    wdata_d     = wdata_q;
    ack_d       = ack_q;
    nack_d      = nack_q;
    scl_oe_d    = scl_oe;
    sda_oe_d    = sda_oe;
    rsp_rdata_d = rsp_rdata;
    rsp_nack_d  = rsp_nack;

    if (state == IDLE) begin
      if (cmd_valid) begin
        state_d = START;
        phase_d = PH_LOW;
        rw_d    = cmd_rw;
        dev_d   = cmd_dev_adr;
        madr_d  = cmd_mem_adr;
        wdata_d = cmd_wdata;
        nack_d  = 1'b0;
        rx_sh_d = 8'h00;
      end
    end else if (state == DONE) begin
      state_d = IDLE;
    end else if (tick) begin
      phase_d = phase + 2'd1;
      case (state)
        START: begin
          case (phase)
            PH_LOW:  begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
            PH_RISE: sda_oe_d = 1'b1;
            PH_FALL: begin
              scl_oe_d   = 1'b1;
              tx_sh_d    = {dev_q, RW_WRITE};
              bit_cnt_d  = 3'd7;
              byte_idx_d = 2'd0;
              state_d    = TX_BYTE;
            end
            default: ;
          endcase
        end
        TX_BYTE: begin
          case (phase)
            PH_LOW:  begin scl_oe_d = 1'b1; sda_oe_d = ~tx_sh[7]; end
            PH_RISE: scl_oe_d = 1'b0;
            PH_FALL: begin
              scl_oe_d = 1'b1;
              tx_sh_d  = {tx_sh[6:0], 1'b0};
              if (bit_cnt == 3'd0) state_d = TX_ACK;
              else bit_cnt_d = bit_cnt - 3'd1;
            end
            default: ;
          endcase
        end
        TX_ACK: begin
          case (phase)
            PH_LOW:  begin scl_oe_d = 1'b1; sda_oe_d = 1'b0; end
            PH_RISE: scl_oe_d = 1'b0;
            PH_HIGH: ack_d = sda_i;
            PH_FALL: begin
              scl_oe_d  = 1'b1;
              bit_cnt_d = 3'd7;
              if (ack_q) begin
                nack_d  = 1'b1;
                state_d = STOP;
              end else if (byte_idx == 2'd0) begin
                tx_sh_d    = madr_q;
                byte_idx_d = 2'd1;
                state_d    = TX_BYTE;
              end else if (byte_idx == 2'd1) begin
                if (rw_q == RW_READ) begin
                  state_d = RSTART;
                end else begin
                  tx_sh_d    = wdata_q;
                  byte_idx_d = 2'd2;
                  state_d    = TX_BYTE;
                end
              end else begin
                state_d = (rw_q == RW_READ) ? RX_BYTE : STOP;
              end
            end
            default: ;
          endcase
        end
        RSTART: begin
          case (phase)
            PH_LOW:  sda_oe_d = 1'b0;
            PH_RISE: scl_oe_d = 1'b0;
            PH_HIGH: sda_oe_d = 1'b1;
            PH_FALL: begin
              scl_oe_d   = 1'b1;
              tx_sh_d    = {dev_q, RW_READ};
              bit_cnt_d  = 3'd7;
              byte_idx_d = 2'd2;
              state_d    = TX_BYTE;
            end
            default: ;
          endcase
        end
        RX_BYTE: begin
          case (phase)
            PH_LOW:  begin scl_oe_d = 1'b1; sda_oe_d = 1'b0; end
            PH_RISE: scl_oe_d = 1'b0;
            PH_HIGH: rx_sh_d = {rx_sh[6:0], sda_i};
            PH_FALL: begin
              scl_oe_d = 1'b1;
              if (bit_cnt == 3'd0) state_d = RX_NACK;
              else bit_cnt_d = bit_cnt - 3'd1;
            end
            default: ;
          endcase
        end
        RX_NACK: begin
          case (phase)
            PH_LOW:  sda_oe_d = 1'b0;
            PH_RISE: scl_oe_d = 1'b0;
            PH_FALL: begin scl_oe_d = 1'b1; state_d = STOP; end
            default: ;
          endcase
        end
        STOP: begin
          case (phase)
            PH_LOW:  begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
            PH_RISE: scl_oe_d = 1'b0;
            PH_HIGH: sda_oe_d = 1'b0;
            PH_FALL: begin
              state_d     = DONE;
              rsp_nack_d  = nack_q;
              rsp_rdata_d = (nack_q || (rw_q == RW_WRITE)) ? 8'h00 : rx_sh;
            end
            default: ;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq with a behavioural I2C slave at 7'h10
// (16-byte register file, NACKs register addresses above 15).
module tb_i2c_master_seq;

  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV_ADR = 7'h10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev_adr = 7'h00;
  logic [7:0] cmd_mem_adr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl_oe, sda_oe;
  logic       scl, sda;
  logic       slv_scl_low, slv_sda_low = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Wired-AND open-drain bus with pull-ups
  assign scl = ~(scl_oe | slv_scl_low);
  assign sda = ~(sda_oe | slv_sda_low);

  i2c_master_seq #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_dev_adr(cmd_dev_adr),
    .cmd_mem_adr(cmd_mem_adr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_nack   (rsp_nack),
    .busy       (busy),
    .scl_i      (scl),
    .sda_i      (sda),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe)
  );

  // ---------------- behavioural slave ----------------
  typedef enum {S_IDLE, S_RX, S_ACK, S_TX, S_MACK} smode_t;
  smode_t     mode = S_IDLE;
  int         bcnt = 0, idx = 0;
  logic [7:0] sh = 8'h00, ptr = 8'h00;
  logic       rd = 1'b0, slv_ack = 1'b0, in_txn = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] mem [16] = '{default: 8'h00};
  logic [7:0] byte_log [$];
  int         sr_cnt = 0, stop_cnt = 0;
  logic       stretch_arm = 1'b0;
  int         stretch_req = 0, stretch_ack = 0, stretch_left = 0;

  always @(scl or sda or rst_n) begin
    if (!rst_n) begin
      mode = S_IDLE;
      slv_sda_low = 1'b0;
      in_txn = 1'b0;
    end else if (scl && prev_scl && prev_sda && !sda) begin
      if (in_txn) sr_cnt++;
      in_txn = 1'b1;
      mode = S_RX;
      bcnt = 0;
      idx = 0;
      sh = 8'h00;
    end else if (scl && prev_scl && !prev_sda && sda) begin
      if (in_txn) stop_cnt++;
      in_txn = 1'b0;
      mode = S_IDLE;
      slv_sda_low = 1'b0;
    end else if (scl && !prev_scl) begin
      if (mode == S_RX) begin
        sh = {sh[6:0], sda};
        bcnt++;
        if (bcnt == 8) begin
          byte_log.push_back(sh);
          if (idx == 0) begin
            slv_ack = (sh[7:1] == SLV_ADR);
            rd = sh[0];
          end else if (idx == 1) begin
            slv_ack = (sh <= 8'd15);
            ptr = sh;
          end else begin
            slv_ack = 1'b1;
            mem[ptr[3:0]] = sh;
          end
        end
      end else if (mode == S_TX) begin
        bcnt++;
      end
    end else if (!scl && prev_scl) begin
      if (mode == S_RX) begin
        if (bcnt == 8) begin
          if (slv_ack) begin
            slv_sda_low = 1'b1;
            mode = S_ACK;
          end else begin
            mode = S_IDLE;
          end
        end else if (stretch_arm && stretch_req == 0 && idx == 2 && bcnt == 4) begin
          stretch_req++;
        end
      end else if (mode == S_ACK) begin
        slv_sda_low = 1'b0;
        bcnt = 0;
        if (rd) begin
          mode = S_TX;
          sh = mem[ptr[3:0]];
          slv_sda_low = ~sh[7];
        end else begin
          mode = S_RX;
          idx++;
        end
      end else if (mode == S_TX) begin
        if (bcnt == 8) begin
          slv_sda_low = 1'b0;
          mode = S_MACK;
        end else begin
          sh = {sh[6:0], 1'b0};
          slv_sda_low = ~sh[7];
        end
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  // Slave clock stretch: hold SCL low for 37 clocks when requested
  always @(posedge clk) begin
    if (stretch_req != stretch_ack) begin
      stretch_ack  <= stretch_req;
      stretch_left <= 37;
    end else if (stretch_left != 0) begin
      stretch_left <= stretch_left - 1;
    end
  end
  assign slv_scl_low = (stretch_left != 0);

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic acc_busy, acc_ready;

  task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] madr,
                         input logic [7:0] wdata, output logic [7:0] rdata,
                         output logic nack, output logic done);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_rw      = rw;
    cmd_dev_adr = dev;
    cmd_mem_adr = madr;
    cmd_wdata   = wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_busy  = busy;
    acc_ready = cmd_ready;
    done  = 1'b0;
    rdata = 8'hxx;
    nack  = 1'bx;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        done  = 1'b1;
        rdata = rsp_rdata;
        nack  = rsp_nack;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] rd_q;
    logic       nk, dn;
    int         base, sr0, stop0;

    repeat (3) @(negedge clk);
    check("rst_scl_oe",    scl_oe, 0);
    check("rst_sda_oe",    sda_oe, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy",      busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_rsp_nack",  rsp_nack, 0);

    // 1: write A5 to register 03
    base = byte_log.size();
    run_cmd(1'b0, 7'h10, 8'h03, 8'hA5, rd_q, nk, dn);
    check("t1_done",       dn, 1);
    check("t1_busy_acc",   acc_busy, 1);
    check("t1_ready_acc",  acc_ready, 0);
    check("t1_nack",       nk, 0);
    check("t1_rdata",      rd_q, 8'h00);
    check("t1_nbytes",     byte_log.size() - base, 3);
    check("t1_byte0",      byte_log[base], 8'h20);
    check("t1_byte1",      byte_log[base+1], 8'h03);
    check("t1_byte2",      byte_log[base+2], 8'hA5);
    check("t1_mem",        mem[3], 8'hA5);
    check("t1_ready_end",  cmd_ready, 1);

    // 2: write 5A to register 00, then read it back
    run_cmd(1'b0, 7'h10, 8'h00, 8'h5A, rd_q, nk, dn);
    check("t2w_done", dn, 1);
    check("t2w_nack", nk, 0);
    base = byte_log.size();
    sr0  = sr_cnt;
    run_cmd(1'b1, 7'h10, 8'h00, 8'h00, rd_q, nk, dn);
    check("t2r_done",  dn, 1);
    check("t2r_rdata", rd_q, 8'h5A);
    check("t2r_nack",  nk, 0);
    check("t2r_sr",    sr_cnt - sr0, 1);
    check("t2r_nbytes", byte_log.size() - base, 3);
    check("t2r_devr",  byte_log[base+2], 8'h21);

    // 3: absent device
    base  = byte_log.size();
    stop0 = stop_cnt;
    run_cmd(1'b0, 7'h22, 8'h01, 8'h77, rd_q, nk, dn);
    check("t3_done",   dn, 1);
    check("t3_nack",   nk, 1);
    check("t3_rdata",  rd_q, 8'h00);
    check("t3_nbytes", byte_log.size() - base, 1);
    check("t3_byte0",  byte_log[base], 8'h44);
    check("t3_stop",   stop_cnt - stop0, 1);

    // 4: register address out of range
    base = byte_log.size();
    run_cmd(1'b0, 7'h10, 8'h20, 8'hC3, rd_q, nk, dn);
    check("t4_done",   dn, 1);
    check("t4_nack",   nk, 1);
    check("t4_rdata",  rd_q, 8'h00);
    check("t4_nbytes", byte_log.size() - base, 2);
    check("t4_scl",    scl, 1);
    check("t4_sda",    sda, 1);

    // 4b: read on a NACKed register returns zero even though shifting never ran
    run_cmd(1'b1, 7'h10, 8'h30, 8'h00, rd_q, nk, dn);
    check("t4r_nack",  nk, 1);
    check("t4r_rdata", rd_q, 8'h00);

    // 5: reset in the middle of the address byte
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev_adr = 7'h10;
    cmd_mem_adr = 8'h05; cmd_wdata = 8'h11;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_scl_oe", scl_oe, 0);
    check("t5_sda_oe", sda_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready", cmd_ready, 1);
    check("t5_busy",  busy, 0);
    run_cmd(1'b0, 7'h10, 8'h07, 8'h3C, rd_q, nk, dn);
    check("t5_done", dn, 1);
    check("t5_nack", nk, 0);
    check("t5_mem7", mem[7], 8'h3C);
    check("t5_mem5", mem[5], 8'h00);

`ifdef I2C_STRETCH_EN
    // 6: slave stretches SCL in the data byte
    stretch_arm = 1'b1;
    run_cmd(1'b0, 7'h10, 8'h09, 8'hA5, rd_q, nk, dn);
    check("t6_done",    dn, 1);
    check("t6_stretch", stretch_req, 1);
    check("t6_nack",    nk, 0);
    check("t6_mem",     mem[9], 8'hA5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
